// File: rtl/divider_radix2.sv
// divider_radix2: iterative radix-2 restoring divider with RISC-V
// DIV/DIVU/REM/REMU semantics. One quotient bit per cycle, a one-cycle
// fast path for divide-by-zero and signed overflow, a busy/done
// handshake and a kill input that drops an in-flight divide.
module divider_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             kill,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = (~v) + ONE_W;
    endfunction

    // Magnitude of an operand; unsigned operands pass through unchanged.
    // The most negative value maps to 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                    input logic            is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] wq_r;
    logic [WIDTH-1:0] dvs_r;
    logic             sign_r;
    logic             dnd_sign_r;
    logic             dvs_sign_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic             special_s;
    logic             sign_load_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] q_final_s;
    logic [WIDTH-1:0] r_final_s;

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Trial subtraction of the shifted partial remainder; bit WIDTH set means negative.
    assign trial_s = {p_r, wq_r[WIDTH-1]} - {1'b0, dvs_r};

    // Decode request acceptance and the fast-path special cases on raw inputs.
    always_comb begin
        accept_s    = 1'b0;
        div_zero_s  = 1'b0;
        overflow_s  = 1'b0;
        special_s   = 1'b0;
        sign_load_s = 1'b0;
        if ((state_r == ST_IDLE) && start && !kill) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        div_zero_s = (divisor == ZERO_W);
        overflow_s = sign && (dividend == MOST_NEG_W) && (divisor == ONES_W);
        special_s  = div_zero_s || overflow_s;
        if ((state_r == ST_SIGN) && !kill) begin
            sign_load_s = 1'b1;
        end else begin
            sign_load_s = 1'b0;
        end
    end

    // Apply result signs: quotient negative on differing signs, remainder follows dividend.
    always_comb begin
        q_final_s = wq_r;
        r_final_s = p_r;
        if (sign_r && (dnd_sign_r ^ dvs_sign_r)) begin
            q_final_s = negate(wq_r);
        end else begin
            q_final_s = wq_r;
        end
        if (sign_r && dnd_sign_r) begin
            r_final_s = negate(p_r);
        end else begin
            r_final_s = p_r;
        end
    end

    // Next-state logic; kill returns to IDLE from any busy state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (special_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_SIGN;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_SIGN: begin
                if (kill) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and the registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            // DONE is only ever entered without kill, so this is the done pulse.
            done_r  <= (state_next_s == ST_DONE);
            if (accept_s && special_s) begin
                if (div_zero_s) begin
                    quotient_r  <= ONES_W;
                    remainder_r <= dividend;
                end else begin
                    quotient_r  <= MOST_NEG_W;
                    remainder_r <= ZERO_W;
                end
            end else if (sign_load_s) begin
                quotient_r  <= q_final_s;
                remainder_r <= r_final_s;
            end
        end
    end

    // Working registers: operand capture and one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            p_r        <= ZERO_W;
            wq_r       <= ZERO_W;
            dvs_r      <= ZERO_W;
            sign_r     <= 1'b0;
            dnd_sign_r <= 1'b0;
            dvs_sign_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= CNT_LAST;
            p_r        <= ZERO_W;
            wq_r       <= magnitude(dividend, sign);
            dvs_r      <= magnitude(divisor, sign);
            sign_r     <= sign;
            dnd_sign_r <= dividend[WIDTH-1];
            dvs_sign_r <= divisor[WIDTH-1];
        end else if ((state_r == ST_CALC) && !kill) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (!trial_s[WIDTH]) begin
                p_r  <= trial_s[WIDTH-1:0];
                wq_r <= {wq_r[WIDTH-2:0], 1'b1};
            end else begin
                p_r  <= {p_r[WIDTH-2:0], wq_r[WIDTH-1]};
                wq_r <= {wq_r[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
